// File: rtl/ads127l01_acq_ctrl.sv
// ads127l01_acq_ctrl
// Drives the power-up pins of one ADS127L01 running in frame-sync master mode.
// Captures each serial frame the ADC sends and emits it as one sign-extended
// 32-bit sample on an AXI-Stream master.
//
// Ports
//   aclk, aresetn        system clock, asynchronous active-low reset
//   enable               level: 1 = bring the ADC up and acquire, 0 = stop
//   adc_sck/dout/fsync   ADC serial interface, asynchronous to aclk
//   adc_reset_n          ADC reset pin, active low
//   adc_start            ADC start pin
//   m_axis_*             sample stream (tdata sign-extended from DATA_BITS)
//   running              high while the sequencer is in RUN
//   overflow             sticky flag; cleared by a clr_overflow pulse
//   frame_cnt            count of samples accepted downstream, wraps
module ads127l01_acq_ctrl #(
  parameter int DATA_BITS   = 24,
  parameter int RST_CYCLES  = 64,
  parameter int WAKE_CYCLES = 1024
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic        adc_sck,
  input  logic        adc_dout,
  input  logic        adc_fsync,
  output logic        adc_reset_n,
  output logic        adc_start,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        running,
  output logic        overflow,
  input  logic        clr_overflow,
  output logic [31:0] frame_cnt
);

  localparam int MAX_CYCLES = (RST_CYCLES > WAKE_CYCLES) ? RST_CYCLES : WAKE_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam int BW         = 6;

  typedef enum logic [1:0] {IDLE, RESET, WAKE, RUN} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  // Bit 0 is the metastability stage, bit 1 the synchronised value and bit 2
  // the delayed copy used for rising-edge detection.
  logic [2:0]             sck_sr_q;
  logic [2:0]             fsync_sr_q;
  logic [1:0]             dout_sr_q;
  logic                   sck_rise, fsync_rise, dout_sync;

  logic                   armed_q, armed_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   shifted;
  logic signed [DATA_BITS-1:0] shifted_s;
  logic [31:0]            sample_ext;
  logic                   frame_done;

  logic [31:0]            tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   overflow_q, overflow_d;
  logic [31:0]            frame_cnt_q, frame_cnt_d;
  logic                   handshake;

  // Input synchronisers for the ADC-driven pins.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sck_sr_q   <= '0;
      fsync_sr_q <= '0;
      dout_sr_q  <= '0;
    end else begin
      sck_sr_q   <= {sck_sr_q[1:0], adc_sck};
      fsync_sr_q <= {fsync_sr_q[1:0], adc_fsync};
      dout_sr_q  <= {dout_sr_q[0], adc_dout};
    end
  end

  assign sck_rise   = sck_sr_q[1] & ~sck_sr_q[2];
  assign fsync_rise = fsync_sr_q[1] & ~fsync_sr_q[2];
  assign dout_sync  = dout_sr_q[1];

  // Sequencer state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Power-up sequence. Pin levels decode directly from the state, so
  // adc_reset_n rises on the edge that enters WAKE and adc_start on the edge
  // that enters RUN. Dropping enable aborts from any state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    adc_reset_n = 1'b0;
    adc_start   = 1'b0;
    running     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = RESET;
      end
      RESET: begin
        if (cnt_q == CW'(RST_CYCLES - 1)) state_d = WAKE;
        else                              cnt_d   = cnt_q + 1'b1;
      end
      WAKE: begin
        adc_reset_n = 1'b1;
        if (cnt_q == CW'(WAKE_CYCLES - 1)) state_d = RUN;
        else                               cnt_d   = cnt_q + 1'b1;
      end
      RUN: begin
        adc_reset_n = 1'b1;
        adc_start   = 1'b1;
        running     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Frame capture registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      armed_q   <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      armed_q   <= armed_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // Frame deserialiser. fsync has priority over a coincident sck edge, and a
  // new fsync silently restarts any partial frame. frame_done is asserted in
  // the cycle the last bit arrives, using the shift value including that bit.
  always_comb begin
    armed_d    = armed_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
    shifted    = {shift_q[DATA_BITS-2:0], dout_sync};
    if (state_q != RUN) begin
      armed_d   = 1'b0;
      bit_cnt_d = '0;
    end else if (fsync_rise) begin
      armed_d   = 1'b1;
      bit_cnt_d = '0;
    end else if (sck_rise && armed_q) begin
      shift_d = shifted;
      if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
        frame_done = 1'b1;
        armed_d    = 1'b0;
        bit_cnt_d  = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  assign shifted_s  = shifted;
  assign sample_ext = 32'(shifted_s);
  assign handshake  = tvalid_q & m_axis_tready;

  // Stream output registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      overflow_q  <= overflow_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // A completed frame loads whenever the output slot is free or being emptied
  // this cycle; otherwise it is dropped and flagged. The overflow set is
  // applied after the clear so a coincident set wins.
  always_comb begin
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    overflow_d  = overflow_q;
    frame_cnt_d = frame_cnt_q;
    if (handshake) frame_cnt_d = frame_cnt_q + 32'd1;
    if (clr_overflow) overflow_d = 1'b0;
    if (frame_done) begin
      if (!tvalid_q || m_axis_tready) begin
        tdata_d  = sample_ext;
        tvalid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (handshake) begin
      tvalid_d = 1'b0;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign overflow      = overflow_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_ads127l01_acq_ctrl.sv
// tb_ads127l01_acq_ctrl
// Scoreboard bench for ads127l01_acq_ctrl with short reset/wake timings.
// Stimulus pushes expected samples into expQ as frames are sent; the monitor
// pops and compares on every stream handshake.
module tb_ads127l01_acq_ctrl;

  localparam int RST  = 4;
  localparam int WAKE = 8;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic        adc_sck;
  logic        adc_dout;
  logic        adc_fsync;
  logic        adc_reset_n;
  logic        adc_start;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        running;
  logic        overflow;
  logic        clr_overflow;
  logic [31:0] frame_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] expQ[$];
  logic [31:0] expData;

  ads127l01_acq_ctrl #(
    .DATA_BITS  (24),
    .RST_CYCLES (RST),
    .WAKE_CYCLES(WAKE)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .enable       (enable),
    .adc_sck      (adc_sck),
    .adc_dout     (adc_dout),
    .adc_fsync    (adc_fsync),
    .adc_reset_n  (adc_reset_n),
    .adc_start    (adc_start),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .running      (running),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .frame_cnt    (frame_cnt)
  );

  always #5 aclk = ~aclk;

  // Compares one value and keeps the running tallies.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Advances n rising edges and steps just past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #2;
  endtask

  // Sends an fsync pulse followed by the low nbits of value, MSB first.
  task automatic applyStimulus(input logic [31:0] value, input int nbits);
    adc_fsync = 1'b1;
    tick(4);
    adc_fsync = 1'b0;
    tick(4);
    for (int i = nbits - 1; i >= 0; i--) begin
      adc_dout = value[i];
      tick(4);
      adc_sck = 1'b1;
      tick(4);
      adc_sck = 1'b0;
    end
    tick(6);
  endtask

  // Raises enable and checks the pin timing through to RUN.
  task automatic powerUp();
    enable = 1'b1;
    tick(RST);
    checkOutput("reset_n_low_before", 32'(adc_reset_n), 32'd0);
    tick(1);
    checkOutput("reset_n_rise", 32'(adc_reset_n), 32'd1);
    tick(WAKE - 1);
    checkOutput("start_low_before", 32'(adc_start), 32'd0);
    tick(1);
    checkOutput("start_rise", 32'(adc_start), 32'd1);
    checkOutput("running_rise", 32'(running), 32'd1);
  endtask

  // Waits a bounded time for all expected samples to be consumed.
  task automatic waitDrain(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
  endtask

  // Scoreboard monitor: one comparison per accepted sample.
  always @(negedge aclk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_sample: got %h, expected none", m_axis_tdata);
      end else begin
        expData = expQ.pop_front();
        checkOutput("sample", m_axis_tdata, expData);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    aresetn       = 1'b0;
    enable        = 1'b0;
    adc_sck       = 1'b0;
    adc_dout      = 1'b0;
    adc_fsync     = 1'b0;
    m_axis_tready = 1'b0;
    clr_overflow  = 1'b0;
    tick(3);
    checkOutput("rst_reset_n", 32'(adc_reset_n), 32'd0);
    checkOutput("rst_start", 32'(adc_start), 32'd0);
    checkOutput("rst_tdata", m_axis_tdata, 32'd0);
    checkOutput("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("rst_running", 32'(running), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_frame_cnt", frame_cnt, 32'd0);
    aresetn = 1'b1;
    tick(3);

    $display("[TB] T1 power-up");
    powerUp();
    enable = 1'b0;
    tick(1);
    checkOutput("t1_reset_n_off", 32'(adc_reset_n), 32'd0);
    checkOutput("t1_start_off", 32'(adc_start), 32'd0);
    checkOutput("t1_running_off", 32'(running), 32'd0);

    $display("[TB] T2 frame decode");
    m_axis_tready = 1'b1;
    powerUp();
    expQ.push_back(32'h007FFFFF);
    applyStimulus(32'h007FFFFF, 24);
    expQ.push_back(32'hFF800001);
    applyStimulus(32'h00800001, 24);
    waitDrain(50);
    tick(2);
    checkOutput("t2_frame_cnt", frame_cnt, 32'd2);
    checkOutput("t2_overflow", 32'(overflow), 32'd0);

    // Counts below are cumulative across tests: T2 left frame_cnt at 2.
    $display("[TB] T3 backpressure");
    m_axis_tready = 1'b0;
    expQ.push_back(32'hFFABCDEF);
    applyStimulus(32'h00ABCDEF, 24);
    applyStimulus(32'h00000042, 24);
    checkOutput("t3_overflow_set", 32'(overflow), 32'd1);
    checkOutput("t3_frame_cnt_held", frame_cnt, 32'd2);
    checkOutput("t3_tvalid_held", 32'(m_axis_tvalid), 32'd1);
    checkOutput("t3_tdata_held", m_axis_tdata, 32'hFFABCDEF);
    m_axis_tready = 1'b1;
    waitDrain(20);
    tick(2);
    checkOutput("t3_frame_cnt", frame_cnt, 32'd3);
    checkOutput("t3_tvalid_drop", 32'(m_axis_tvalid), 32'd0);
    checkOutput("t3_overflow_sticky", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    checkOutput("t3_overflow_clr", 32'(overflow), 32'd0);

    $display("[TB] T4 short frame");
    applyStimulus(32'h000003A5, 10);
    expQ.push_back(32'h00123456);
    applyStimulus(32'h00123456, 24);
    waitDrain(50);
    tick(2);
    checkOutput("t4_overflow", 32'(overflow), 32'd0);
    checkOutput("t4_frame_cnt", frame_cnt, 32'd4);

    $display("[TB] T5 abort");
    applyStimulus(32'h00000ABC, 12);
    enable = 1'b0;
    tick(1);
    checkOutput("t5_running_off", 32'(running), 32'd0);
    checkOutput("t5_start_off", 32'(adc_start), 32'd0);
    tick(10);
    checkOutput("t5_no_sample", 32'(m_axis_tvalid), 32'd0);
    checkOutput("t5_frame_cnt", frame_cnt, 32'd4);
    powerUp();
    expQ.push_back(32'h00000001);
    applyStimulus(32'h00000001, 24);
    waitDrain(50);
    tick(2);
    checkOutput("t5_frame_cnt_after", frame_cnt, 32'd5);

    $display("[TB] T6 async reset");
    m_axis_tready = 1'b0;
    applyStimulus(32'h00654321, 24);
    checkOutput("t6_tvalid_pending", 32'(m_axis_tvalid), 32'd1);
    applyStimulus(32'h0000002A, 6);
    checkOutput("t6_queue_empty", 32'(expQ.size()), 32'd0);
    aresetn = 1'b0;
    #1;
    checkOutput("t6_reset_n", 32'(adc_reset_n), 32'd0);
    checkOutput("t6_start", 32'(adc_start), 32'd0);
    checkOutput("t6_tdata", m_axis_tdata, 32'd0);
    checkOutput("t6_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("t6_running", 32'(running), 32'd0);
    checkOutput("t6_overflow", 32'(overflow), 32'd0);
    checkOutput("t6_frame_cnt", frame_cnt, 32'd0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
